// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// hands each instruction (with its PC) to the decoder.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises a
// sticky fetch_fault and parks the stage in S_HALT until reset. Without it,
// redirect targets are silently word-aligned and fetch_fault stays 0.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchEn,
  input  logic [31:0] branchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        req_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        valid_q;
  logic [31:0] redirect_pc;
  logic [31:0] seq_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
  logic        fault_q;
`endif

  // Next-PC selection: sequential (mod 2^32) or word-aligned redirect target.
  always_comb begin
    seq_pc      = pc_q + 32'd4;
    redirect_pc = branchTarget & ~32'h0000_0003;
    pc_d        = branchEn ? redirect_pc : seq_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign    = branchEn && (branchTarget[1:0] != 2'b00);
`endif
  end

  // Fetch FSM with all handshake/decoder outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= pc_q;
            valid_q   <= 1'b1;
            req_q     <= 1'b0;
            state_q   <= S_VALID;
          end
        end
        S_VALID: begin
          // Redirects are only honoured once the decoder accepts the instruction.
          if (!stall) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
`else
            pc_q    <= pc_d;
            req_q   <= 1'b1;
            state_q <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = inst_pc_q + 32'd4;
  assign inst_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branchEn = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branchEn(branchEn),
    .branchTarget(branchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .inst_pc(inst_pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must be showing after each edge.
  logic [31:0] m_pc, m_inst, m_ipc;
  bit m_idle, m_req, m_valid, m_halt, m_fault;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = RST_PC; m_inst = NOP; m_ipc = RST_PC;
      m_idle = 1; m_req = 0; m_valid = 0; m_halt = 0; m_fault = 0;
    end else if (m_halt) begin
      m_req = 0;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_inst = imem_rdata; m_ipc = m_pc; m_valid = 1; m_req = 0;
      end
    end else if (m_valid && !stall) begin
      m_valid = 0; m_inst = NOP;
      if (TRAP && branchEn && (branchTarget[1:0] != 2'b00)) begin
        m_fault = 1; m_halt = 1;
      end else begin
        m_pc  = branchEn ? {branchTarget[31:2], 2'b00} : m_pc + 32'd4;
        m_req = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imem_req",   imem_req,    m_req);
      chk("m_imem_addr",  imem_addr,   m_pc);
      chk("m_inst",       inst,        m_inst);
      chk("m_inst_pc",    inst_pc,     m_ipc);
      chk("m_pc_plus4",   pc_plus4,    m_ipc + 32'd4);
      chk("m_inst_valid", inst_valid,  m_valid);
      chk("m_fetch_fault", fetch_fault, m_fault);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] g_pc;
    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("R_req", imem_req, 0);
    chk("R_addr", imem_addr, RST_PC);
    chk("R_inst", inst, NOP);
    chk("R_inst_pc", inst_pc, RST_PC);
    chk("R_valid", inst_valid, 0);
    chk("R_fault", fetch_fault, 0);

    // A: ack tied high -> addresses 0,4,8,C with valid every 2nd cycle
    imem_ack = 1; imem_rdata = $urandom; rst = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      imem_rdata = $urandom;
      chk("A_valid_pulse", inst_valid, (i % 2 == 1));
      if (i % 2 == 0) chk("A_addr", imem_addr, 32'(4 * (i / 2)));
      else            chk("A_inst_pc", inst_pc, 32'(4 * (i / 2)));
    end

    // B: ack delayed 3 cycles -> req held 4 cycles at addr 0
    rst = 0; imem_ack = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("B_req_held", imem_req, 1);
      chk("B_addr_stable", imem_addr, 32'h0);
    end
    imem_ack = 1; imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_ack = 0;
    chk("B_inst", inst, 32'h0050_0093);
    chk("B_inst_pc", inst_pc, 32'h0);
    chk("B_valid", inst_valid, 1);
    chk("B_req_drop", imem_req, 0);

    // C: stall 5 cycles holds the instruction, then fetch resumes at +4
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("C_inst", inst, 32'h0050_0093);
      chk("C_inst_pc", inst_pc, 32'h0);
      chk("C_valid", inst_valid, 1);
      chk("C_no_req", imem_req, 0);
    end
    stall = 0;
    @(negedge clk);
    chk("C_next_addr", imem_addr, 32'h4);
    chk("C_next_req", imem_req, 1);

    // D: redirect to 0x100; then a stalled redirect to 0x200
    imem_ack = 1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 0; branchEn = 1; branchTarget = 32'h100;
    @(negedge clk);
    chk("D_branch_addr", imem_addr, 32'h100);
    chk("D_branch_req", imem_req, 1);
    branchEn = 0; imem_ack = 1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 0; stall = 1; branchEn = 1; branchTarget = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("D_stall_no_req", imem_req, 0);
      chk("D_stall_pc", imem_addr, 32'h100);
    end
    stall = 0;
    @(negedge clk);
    chk("D_late_branch", imem_addr, 32'h200);
    branchEn = 0;

    // E: PC wraps from 0xFFFF_FFFC to 0
    imem_ack = 1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 0; branchEn = 1; branchTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("E_top_addr", imem_addr, 32'hFFFF_FFFC);
    branchEn = 0; imem_ack = 1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 0;
    chk("E_top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("E_plus4_wrap", pc_plus4, 32'h0);
    @(negedge clk);
    chk("E_wrap_addr", imem_addr, 32'h0);

    // F: reset during an outstanding request; a late ack is ignored
    imem_ack = 1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    chk("F_pre_addr", imem_addr, 32'h4);
    rst = 0;
    @(negedge clk);
    chk("F_rst_req", imem_req, 0);
    chk("F_rst_pc", imem_addr, RST_PC);
    chk("F_rst_valid", inst_valid, 0);
    rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("F_late_ack_ignored", inst_valid, 0);
    chk("F_req_after_idle", imem_req, 1);
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 0;
    chk("F_fetch_inst", inst, 32'h1234_5678);
    chk("F_fetch_valid", inst_valid, 1);

    // G: misaligned redirect target 0x102
    g_pc = imem_addr;
    branchEn = 1; branchTarget = 32'h102;
    @(negedge clk);
    branchEn = 0;
    if (TRAP) begin
      chk("G_fault", fetch_fault, 1);
      chk("G_halt_req", imem_req, 0);
      chk("G_halt_valid", inst_valid, 0);
      chk("G_pc_kept", imem_addr, g_pc);
      imem_ack = 1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("G_stays_halted", imem_req, 0);
      end
      imem_ack = 0;
    end else begin
      chk("G_aligned_addr", imem_addr, 32'h100);
      chk("G_no_fault", fetch_fault, 0);
    end

    // Randomized run against the model
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 99) != 0);
      imem_ack     = ($urandom_range(0, 2) != 0);
      imem_rdata   = $urandom;
      stall        = ($urandom_range(0, 3) == 0);
      branchEn     = ($urandom_range(0, 2) == 0);
      branchTarget = $urandom;
      if ($urandom_range(0, 15) != 0) branchTarget[1:0] = 2'b00;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
